// File: rtl/cam_box_downscale_if.sv
// Pixel stream bundle for the box downscaler: cropped input stream in, averaged stream out.
interface cam_box_downscale_if #(
    parameter int P_DEPTH = 10
);
    logic [10:0]        in_x;
    logic [10:0]        in_y;
    logic               in_valid;
    logic [P_DEPTH-1:0] in_data_00;
    logic [P_DEPTH-1:0] in_data_01;
    logic [P_DEPTH-1:0] in_data_10;
    logic [10:0]        out_x;
    logic [10:0]        out_y;
    logic               out_valid;
    logic [P_DEPTH-1:0] out_data_00;
    logic [P_DEPTH-1:0] out_data_01;
    logic [P_DEPTH-1:0] out_data_10;
    logic               out_eof;

    modport master (
        output in_x, in_y, in_valid, in_data_00, in_data_01, in_data_10,
        input  out_x, out_y, out_valid, out_data_00, out_data_01, out_data_10, out_eof
    );

    modport slave (
        input  in_x, in_y, in_valid, in_data_00, in_data_01, in_data_10,
        output out_x, out_y, out_valid, out_data_00, out_data_01, out_data_10, out_eof
    );
endinterface

// File: rtl/cam_box_downscale.sv
// Box-average integer downscaler (S x S blocks, S = 2^SCALE_LOG2) with a line buffer of vertical sums.
// Optional feature macro: CAM_BOX_DOWNSCALE_ROUND_EN selects round-half-up instead of truncation.
module cam_box_downscale #(
    parameter int P_DEPTH    = 10,
    parameter int IN_WIDTH   = 240,
    parameter int IN_HEIGHT  = 540,
    parameter int SCALE_LOG2 = 1
) (
    input  logic                 in_pclk,
    input  logic                 in_rst,
    cam_box_downscale_if.slave   bus
);
    localparam int S     = 1 << SCALE_LOG2;
    localparam int OUT_W = IN_WIDTH >> SCALE_LOG2;
    localparam int OUT_H = IN_HEIGHT >> SCALE_LOG2;
    localparam int AW    = P_DEPTH + 2 * SCALE_LOG2;
    localparam int LBW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [10:0] X_LIM  = 11'(OUT_W * S);
    localparam logic [10:0] Y_LIM  = 11'(OUT_H * S);
    localparam logic [10:0] X_LAST = 11'(OUT_W - 1);
    localparam logic [10:0] Y_LAST = 11'(OUT_H - 1);

    logic [SCALE_LOG2-1:0] col_ph, row_ph;
    logic [10:0]           addr, blk_y;
    logic [LBW-1:0]        lb_idx;
    logic                  blk_start, blk_end, row_first, row_last;
    logic                  take, s1_vld_d;
    logic                  armed_q, armed_d;

    logic [2:0][AW-1:0]    pix, hsum, lbsum;
    logic [2:0][AW-1:0]    hacc_q, hacc_d;
    logic [2:0][AW-1:0]    rd_q;
    logic [2:0][AW-1:0]    lb_mem [OUT_W];

    logic                  s1_vld_q, s1_eof_q;
    logic [2:0][AW-1:0]    s1_tot_q;
    logic [10:0]           s1_x_q, s1_y_q;
    logic [2:0][P_DEPTH-1:0] avg;

    logic                  out_valid_q, out_eof_q;
    logic [10:0]           out_x_q, out_y_q;
    logic [2:0][P_DEPTH-1:0] out_d_q;

    always_comb begin
        col_ph    = bus.in_x[SCALE_LOG2-1:0];
        row_ph    = bus.in_y[SCALE_LOG2-1:0];
        addr      = bus.in_x >> SCALE_LOG2;
        blk_y     = bus.in_y >> SCALE_LOG2;
        lb_idx    = addr[LBW-1:0];
        blk_start = (col_ph == '0);
        blk_end   = &col_ph;
        row_first = (row_ph == '0);
        row_last  = &row_ph;
        // After reset nothing is accepted until a block's top-left pixel re-arms the datapath.
        take      = bus.in_valid && (bus.in_x < X_LIM) && (bus.in_y < Y_LIM)
                    && (armed_q || (blk_start && row_first));
        armed_d   = armed_q | take;
        s1_vld_d  = take && blk_end && row_last;
        pix[0]    = AW'(bus.in_data_00);
        pix[1]    = AW'(bus.in_data_01);
        pix[2]    = AW'(bus.in_data_10);
        for (int c = 0; c < 3; c++) begin
            hsum[c]  = blk_start ? pix[c] : hacc_q[c] + pix[c];
            lbsum[c] = rd_q[c] + hsum[c];
        end
        hacc_d = take ? hsum : hacc_q;
    end

    always_ff @(posedge in_pclk) begin
        if (in_rst) begin
            hacc_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            hacc_q  <= hacc_d;
            armed_q <= armed_d;
        end
    end

    // Read is launched on the first column of a block and held; row 0 overwrites, so no clear is needed.
    always_ff @(posedge in_pclk) begin
        if (take && blk_start)
            rd_q <= lb_mem[lb_idx];
        if (take && blk_end && !row_last)
            lb_mem[lb_idx] <= row_first ? hsum : lbsum;
    end

    always_ff @(posedge in_pclk) begin
        if (in_rst) begin
            s1_vld_q <= 1'b0;
            s1_eof_q <= 1'b0;
            s1_tot_q <= '0;
            s1_x_q   <= '0;
            s1_y_q   <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            if (s1_vld_d) begin
                s1_tot_q <= lbsum;
                s1_x_q   <= addr;
                s1_y_q   <= blk_y;
                s1_eof_q <= (addr == X_LAST) && (blk_y == Y_LAST);
            end
        end
    end

`ifdef CAM_BOX_DOWNSCALE_ROUND_EN
    localparam logic [AW:0] RND_HALF = (AW + 1)'(1) << (2 * SCALE_LOG2 - 1);
    always_comb begin
        for (int c = 0; c < 3; c++)
            avg[c] = P_DEPTH'(({1'b0, s1_tot_q[c]} + RND_HALF) >> (2 * SCALE_LOG2));
    end
`else
    always_comb begin
        for (int c = 0; c < 3; c++)
            avg[c] = P_DEPTH'(s1_tot_q[c] >> (2 * SCALE_LOG2));
    end
`endif

    always_ff @(posedge in_pclk) begin
        if (in_rst) begin
            out_valid_q <= 1'b0;
            out_eof_q   <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_d_q     <= '0;
        end else begin
            out_valid_q <= s1_vld_q;
            out_eof_q   <= s1_vld_q && s1_eof_q;
            if (s1_vld_q) begin
                out_x_q <= s1_x_q;
                out_y_q <= s1_y_q;
                out_d_q <= avg;
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_eof     = out_eof_q;
    assign bus.out_x       = out_x_q;
    assign bus.out_y       = out_y_q;
    assign bus.out_data_00 = out_d_q[0];
    assign bus.out_data_01 = out_d_q[1];
    assign bus.out_data_10 = out_d_q[2];
endmodule

// File: tb/tb_cam_box_downscale.sv
// Scoreboard bench: frame-image reference model pushes expected block averages; a monitor pops on out_valid.
module tb_cam_box_downscale;
    localparam int PD = 10;
    localparam int W  = 19;
    localparam int H  = 13;
    localparam int SL = 1;
    localparam int S  = 1 << SL;
    localparam int OW = W >> SL;
    localparam int OH = H >> SL;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cam_box_downscale_if #(.P_DEPTH(PD)) bus();

    cam_box_downscale #(
        .P_DEPTH(PD), .IN_WIDTH(W), .IN_HEIGHT(H), .SCALE_LOG2(SL)
    ) dut (
        .in_pclk(clk),
        .in_rst (rst),
        .bus    (bus)
    );

    typedef struct {
        int x; int y; int d0; int d1; int d2; int eof; int cyc;
    } exp_t;

    exp_t sb[$];
    int   img[H][W][3];
    int   cval[3];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   armed = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected out_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_x",       bus.out_x,       e.x);
                    check("out_y",       bus.out_y,       e.y);
                    check("out_data_00", bus.out_data_00, e.d0);
                    check("out_data_01", bus.out_data_01, e.d1);
                    check("out_data_10", bus.out_data_10, e.d2);
                    check("out_eof",     bus.out_eof,     e.eof);
                    check("latency cycle", cyc, e.cyc);
                end
            end else if (bus.out_eof) begin
                check("out_eof without out_valid", 1, 0);
            end
        end
    end

    function automatic int val(input int kind, input int x, input int y, input int ch);
        case (kind)
            0:       return int'($urandom_range(1023));
            1:       return cval[ch];
            2:       return (x * 37 + y * 11 + ch * 100) % 1024;
            3:       return 1 + (x % 2) + 2 * (y % 2) + ch;
            default: return 0;
        endcase
    endfunction

    function automatic int avg_of(input int sum);
`ifdef CAM_BOX_DOWNSCALE_ROUND_EN
        return (sum + (S * S) / 2) / (S * S);
`else
        return sum / (S * S);
`endif
    endfunction

    task automatic drive(input int x, input int y, input int kind, input int gap);
        int   d[3];
        int   sum[3];
        exp_t e;
        while (int'($urandom_range(99)) < gap) begin
            bus.in_valid   = 1'b0;
            bus.in_x       = 11'($urandom);
            bus.in_y       = 11'($urandom);
            bus.in_data_00 = PD'($urandom);
            @(posedge clk); #1;
        end
        for (int c = 0; c < 3; c++) d[c] = val(kind, x, y, c);
        bus.in_valid   = 1'b1;
        bus.in_x       = 11'(x);
        bus.in_y       = 11'(y);
        bus.in_data_00 = PD'(d[0]);
        bus.in_data_01 = PD'(d[1]);
        bus.in_data_10 = PD'(d[2]);
        if (x < OW * S && y < OH * S) begin
            if (armed == 0 && x % S == 0 && y % S == 0) armed = 1;
            if (armed != 0) begin
                for (int c = 0; c < 3; c++) img[y][x][c] = d[c];
                if (x % S == S - 1 && y % S == S - 1) begin
                    for (int c = 0; c < 3; c++) begin
                        sum[c] = 0;
                        for (int dy = 0; dy < S; dy++)
                            for (int dx = 0; dx < S; dx++)
                                sum[c] += img[y - dy][x - dx][c];
                    end
                    e.x   = x / S;
                    e.y   = y / S;
                    e.d0  = avg_of(sum[0]);
                    e.d1  = avg_of(sum[1]);
                    e.d2  = avg_of(sum[2]);
                    e.eof = (e.x == OW - 1 && e.y == OH - 1) ? 1 : 0;
                    e.cyc = cyc + 2;
                    sb.push_back(e);
                end
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Raster-index range [first, last) of a W x H frame.
    task automatic frame(input int kind, input int gap, input int first, input int last);
        for (int i = first; i < last; i++) drive(i % W, i / W, kind, gap);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst   = 1'b1;
        armed = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outputs",
              {bus.out_valid, bus.out_eof, bus.out_x, bus.out_y,
               bus.out_data_00, bus.out_data_01, bus.out_data_10}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_x       = '0;
        bus.in_y       = '0;
        bus.in_data_00 = '0;
        bus.in_data_01 = '0;
        bus.in_data_10 = '0;
        do_reset();

        cval = '{100, 0, 1023};
        frame(1, 0, 0, W * H);
        frame(3, 0, 0, W * H);
        frame(2, 0, 0, W * H);
        frame(2, 50, 0, W * H);
        frame(0, 30, 0, W * H);

        // truncated frame: wraps back to (0,0) after line 5
        frame(0, 20, 0, 6 * W);
        frame(0, 0, 0, W * H);

        // reset mid-line 7, then the old frame continues and re-arms at line 8
        frame(2, 0, 0, 7 * W + 9);
        repeat (4) begin @(posedge clk); #1; end
        do_reset();
        frame(2, 20, 7 * W + 9, W * H);

        cval = '{500, 500, 500};
        frame(1, 30, 0, W * H);
        cval = '{1023, 1023, 1023};
        frame(1, 0, 0, W * H);

        repeat (6) @(posedge clk);
        @(negedge clk);
        check("scoreboard drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
